snake_game_ctrl: RTL and testbench
==================================

// Module: snake_game_ctrl
// PURPOSE
//  Upstream controller for the snake draw stage. It owns the game state machine (START/PLAY/GAME_OVER),
//  the direction register with reversal lockout, and the movement update pulse.
//  It also detects head-vs-body and head-vs-border collisions from the pixel-scan activity flags.
//  It drives direction, game_state and update to the snake draw stage and consumes its head/body flags.
// PARAMETERS
//  BIT              10   pixel coordinate width
//  H_ACTIVE         640  visible width in pixels
//  V_ACTIVE         480  visible height in pixels
//  BORDER           5    border thickness in pixels; a head pixel inside the border is a wall hit (must be >=1)
//  FRAMES_PER_STEP  8    frames between snake moves (>=1)
//  GAME_OVER_FRAMES 120  frames spent in GAME_OVER before returning to START (>=1)
// PORTS
//  clk               in   1    system/pixel clock
//  reset             in   1    synchronous, active-high
//  frame_tick        in   1    one-cycle pulse per frame, issued after the last active line
//  video_active      in   1    current x_pos/y_pos is a visible pixel
//  x_pos             in   BIT  current scan x
//  y_pos             in   BIT  current scan y
//  snake_head_active in   1    head covers current pixel
//  snake_body_active in   1    body covers current pixel
//  btn_up            in   1    debounced, synchronised level; btn_down/btn_left/btn_right likewise
//  direction         out  3    0 IDLE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT
//  game_state        out  2    00 START, 01 PLAY, 11 GAME_OVER (10 never driven)
//  update            out  1    one-cycle move strobe
//  score             out  8    completed moves in the current game, saturating
// BEHAVIOUR
//  Reset values: game_state=START, direction=IDLE, update=0, score=0, all counters and latches=0.
//  All outputs are registered.
//  Button priority: up > down > left > right. press = any button high in a cycle.
//  START:
//   - direction held at IDLE; score and frame counter held at 0.
//   - On the first cycle a button is high: next cycle game_state=PLAY and direction=the button's direction.
//   - last_moved is loaded with the same direction.
//  PLAY, direction:
//   - On each cycle with a button high, direction takes that button's value, unless it is the opposite of
//     last_moved (UP<->DOWN, LEFT<->RIGHT); in that case the button is ignored.
//   - last_moved <= direction in the cycle update is driven high.
//   - This blocks a reversal built from two quick presses between moves.
//  PLAY, collision latch:
//   - Set on any cycle where video_active && snake_head_active && (snake_body_active ||
//     x_pos<BORDER || x_pos>=H_ACTIVE-BORDER || y_pos<BORDER || y_pos>=V_ACTIVE-BORDER).
//   - Cleared on frame_tick.
//  PLAY, frame_tick handling:
//   - If the latch is set, or the set condition is true in that same cycle:
//     next cycle game_state=GAME_OVER, update stays 0, frame counter is cleared.
//   - Otherwise frame_cnt increments. When it reaches FRAMES_PER_STEP-1 it wraps to 0,
//     update=1 for exactly the next cycle, and score increments (holds at 255).
//   - Latency frame_tick->update is 1 cycle. update is never high outside PLAY.
//  GAME_OVER:
//   - direction=IDLE; score frozen; buttons ignored.
//   - frame_tick increments frame_cnt; after GAME_OVER_FRAMES ticks, next cycle game_state=START and frame_cnt=0.
//   - score is cleared on the START->PLAY transition, not on entry to START.
//  Counters: frame_cnt is wide enough for max(FRAMES_PER_STEP, GAME_OVER_FRAMES)-1.
//   - score uses unsigned 8-bit saturating add.
//  Reset mid-game returns to the reset values on the next cycle from any state.
//   - A button held through reset deassertion starts PLAY one cycle after reset drops.
//  frame_tick and a button in the same cycle: both take effect. The update uses the direction already registered;
//   the button's direction is registered and shows on the direction output the same cycle update goes high.
//   It is not committed as last_moved until the following update.
// TESTING
//  reset, then btn_right pulse -> game_state=01 and direction=4 one cycle later; score=0; update=0.
//  PLAY, no hits, 16 frame_ticks with FRAMES_PER_STEP=8 -> exactly 2 one-cycle update pulses, each 1 cycle after
//   the 8th/16th tick; score=2.
//  PLAY moving RIGHT: btn_up then btn_left before the next update -> direction=3 blocked (last_moved=4),
//   direction stays 1; after the update, btn_left is accepted.
//  Head and body both active at pixel (100,100) with video_active=1 -> next frame_tick gives game_state=11,
//   no update pulse, direction=0.
//  Head active at x_pos=3 (BORDER=5) -> GAME_OVER. Same stimulus with video_active=0 -> stays PLAY.
//  GAME_OVER with GAME_OVER_FRAMES=120 -> START after the 120th frame_tick; buttons ignored meanwhile; score held
//   until the next START->PLAY.
//  reset asserted in PLAY with score=5 -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// Snake game controller: START/PLAY/GAME_OVER state machine, direction register with
// reversal lockout, frame-paced move strobe, saturating score and collision detection.
module snake_game_ctrl #(
  parameter int BIT              = 10,
  parameter int H_ACTIVE         = 640,
  parameter int V_ACTIVE         = 480,
  parameter int BORDER           = 5,
  parameter int FRAMES_PER_STEP  = 8,
  parameter int GAME_OVER_FRAMES = 120
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic           video_active,
  input  logic [BIT-1:0] x_pos,
  input  logic [BIT-1:0] y_pos,
  input  logic           snake_head_active,
  input  logic           snake_body_active,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           btn_left,
  input  logic           btn_right,
  output logic [2:0]     direction,
  output logic [1:0]     game_state,
  output logic           update,
  output logic [7:0]     score
);

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_PLAY  = 2'b01,
    ST_OVER  = 2'b11
  } state_t;

  localparam logic [2:0] DIR_IDLE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  localparam int CNT_MAX = (FRAMES_PER_STEP > GAME_OVER_FRAMES) ? FRAMES_PER_STEP : GAME_OVER_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [CNT_W-1:0] OVER_LAST = CNT_W'(GAME_OVER_FRAMES - 1);

  localparam logic [BIT-1:0] X_LO = BIT'(BORDER);
  localparam logic [BIT-1:0] X_HI = BIT'(H_ACTIVE - BORDER);
  localparam logic [BIT-1:0] Y_LO = BIT'(BORDER);
  localparam logic [BIT-1:0] Y_HI = BIT'(V_ACTIVE - BORDER);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic is_reverse(input logic [2:0] req, input logic [2:0] moved);
    return ((req == DIR_UP)   && (moved == DIR_DOWN))  ||
           ((req == DIR_DOWN) && (moved == DIR_UP))    ||
           ((req == DIR_LEFT) && (moved == DIR_RIGHT)) ||
           ((req == DIR_RIGHT)&& (moved == DIR_LEFT));
  endfunction

  state_t           state, state_n;
  logic [2:0]       last_moved, last_moved_n, direction_n, btn_dir;
  logic             hit_latch, hit_latch_n, update_n, press, hit_now;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_n;
  logic [7:0]       score_n;

  assign press   = btn_up | btn_down | btn_left | btn_right;
  assign btn_dir = btn_up   ? DIR_UP   :
                   btn_down ? DIR_DOWN :
                   btn_left ? DIR_LEFT :
                   btn_right ? DIR_RIGHT : DIR_IDLE;

  assign hit_now = video_active && snake_head_active &&
                   (snake_body_active || (x_pos < X_LO) || (x_pos >= X_HI) ||
                    (y_pos < Y_LO) || (y_pos >= Y_HI));

  always_comb begin
    state_n      = state;
    direction_n  = direction;
    last_moved_n = last_moved;
    hit_latch_n  = hit_latch;
    frame_cnt_n  = frame_cnt;
    update_n     = 1'b0;
    score_n      = score;
    case (state)
      ST_START: begin
        direction_n = DIR_IDLE;
        frame_cnt_n = '0;
        hit_latch_n = 1'b0;
        if (press) begin
          state_n      = ST_PLAY;
          direction_n  = btn_dir;
          last_moved_n = btn_dir;
          score_n      = 8'd0;
        end
      end
      ST_PLAY: begin
        if (press && !is_reverse(btn_dir, last_moved))
          direction_n = btn_dir;
        if (frame_tick) begin
          hit_latch_n = 1'b0;
          if (hit_latch || hit_now) begin
            state_n     = ST_OVER;
            direction_n = DIR_IDLE;
            frame_cnt_n = '0;
          end else if (frame_cnt == STEP_LAST) begin
            // The move uses the direction registered before this cycle's button.
            frame_cnt_n  = '0;
            update_n     = 1'b1;
            score_n      = sat_inc(score);
            last_moved_n = direction;
          end else begin
            frame_cnt_n = frame_cnt + CNT_W'(1);
          end
        end else if (hit_now) begin
          hit_latch_n = 1'b1;
        end
      end
      ST_OVER: begin
        direction_n = DIR_IDLE;
        hit_latch_n = 1'b0;
        if (frame_tick) begin
          if (frame_cnt == OVER_LAST) begin
            state_n     = ST_START;
            frame_cnt_n = '0;
          end else begin
            frame_cnt_n = frame_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n     = ST_START;
        direction_n = DIR_IDLE;
        frame_cnt_n = '0;
        hit_latch_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_START;
      direction  <= DIR_IDLE;
      last_moved <= DIR_IDLE;
      hit_latch  <= 1'b0;
      frame_cnt  <= '0;
      update     <= 1'b0;
      score      <= 8'd0;
    end else begin
      state      <= state_n;
      direction  <= direction_n;
      last_moved <= last_moved_n;
      hit_latch  <= hit_latch_n;
      frame_cnt  <= frame_cnt_n;
      update     <= update_n;
      score      <= score_n;
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed vector table, hand-written game sequences and
// randomized traffic, all compared against a tick-counting reference model.
module tb_snake_game_ctrl;

  localparam int BIT = 10;
  localparam int HA  = 640;
  localparam int VA  = 480;
  localparam int BRD = 5;
  localparam int FPS = 8;
  localparam int GOF = 120;

  logic           clk = 1'b0;
  logic           reset, frame_tick, video_active;
  logic [BIT-1:0] x_pos, y_pos;
  logic           snake_head_active, snake_body_active;
  logic           btn_up, btn_down, btn_left, btn_right;
  logic [2:0]     direction;
  logic [1:0]     game_state;
  logic           update;
  logic [7:0]     score;

  always #5 clk = ~clk;

  snake_game_ctrl #(
    .BIT(BIT), .H_ACTIVE(HA), .V_ACTIVE(VA), .BORDER(BRD),
    .FRAMES_PER_STEP(FPS), .GAME_OVER_FRAMES(GOF)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .video_active(video_active),
    .x_pos(x_pos), .y_pos(y_pos),
    .snake_head_active(snake_head_active), .snake_body_active(snake_body_active),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .direction(direction), .game_state(game_state), .update(update), .score(score)
  );

  typedef struct {
    logic           rst;
    logic           tick;
    logic [3:0]     btn;   // {up, down, left, right}
    logic           va;
    logic [BIT-1:0] x;
    logic [BIT-1:0] y;
    logic           head;
    logic           body;
  } vin_t;

  typedef struct {
    vin_t       in;
    logic [1:0] st;
    logic [2:0] dir;
    logic       upd;
    logic [7:0] sc;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game progress expressed as ticks elapsed and moves made.
  int m_state, m_dir, m_last, m_score, m_ticks;
  bit m_hit, m_upd;

  function automatic vin_t mk(input logic rst, input logic tick, input logic [3:0] btn,
                              input logic va, input int x, input int y,
                              input logic head, input logic body);
    vin_t v;
    v.rst = rst; v.tick = tick; v.btn = btn; v.va = va;
    v.x = BIT'(x); v.y = BIT'(y); v.head = head; v.body = body;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input vin_t v);
    int bdir, nstate, ndir, nlast, nscore, nticks;
    bit nhit, nupd, hit, opp;
    if (v.rst) begin
      m_state = 0; m_dir = 0; m_last = 0; m_score = 0; m_ticks = 0; m_hit = 0; m_upd = 0;
    end else begin
      bdir = v.btn[3] ? 1 : v.btn[2] ? 2 : v.btn[1] ? 3 : v.btn[0] ? 4 : 0;
      hit = v.va && v.head && (v.body || int'(v.x) < BRD || int'(v.x) >= HA - BRD ||
                               int'(v.y) < BRD || int'(v.y) >= VA - BRD);
      nstate = m_state; ndir = m_dir; nlast = m_last; nscore = m_score;
      nticks = m_ticks; nhit = m_hit; nupd = 0;
      if (m_state == 0) begin
        if (bdir != 0) begin
          nstate = 1; ndir = bdir; nlast = bdir; nscore = 0; nticks = 0; nhit = 0;
        end
      end else if (m_state == 1) begin
        // Opposite directions share a pair: {1,2} and {3,4}.
        opp = (bdir != 0) && (m_last != 0) && (bdir != m_last) && ((bdir - 1) / 2 == (m_last - 1) / 2);
        if (bdir != 0 && !opp) ndir = bdir;
        if (v.tick) begin
          nhit = 0;
          if (m_hit || hit) begin
            nstate = 3; ndir = 0; nticks = 0;
          end else begin
            nticks = m_ticks + 1;
            if (nticks % FPS == 0) begin
              nupd = 1;
              nscore = (m_score + 1 > 255) ? 255 : m_score + 1;
              nlast = m_dir;
            end
          end
        end else if (hit) begin
          nhit = 1;
        end
      end else begin
        if (v.tick) begin
          nticks = m_ticks + 1;
          if (nticks == GOF) begin
            nstate = 0; nticks = 0;
          end
        end
      end
      m_state = nstate; m_dir = ndir; m_last = nlast; m_score = nscore;
      m_ticks = nticks; m_hit = nhit; m_upd = nupd;
    end
  endtask

  task automatic step(input vin_t v);
    reset = v.rst; frame_tick = v.tick; video_active = v.va;
    x_pos = v.x; y_pos = v.y; snake_head_active = v.head; snake_body_active = v.body;
    {btn_up, btn_down, btn_left, btn_right} = v.btn;
    model_step(v);
    @(posedge clk);
    #1;
    chk("model_state", int'(game_state), m_state);
    chk("model_dir", int'(direction), m_dir);
    chk("model_update", int'(update), int'(m_upd));
    chk("model_score", int'(score), m_score);
  endtask

  task automatic idle();
    step(mk(0, 0, 4'b0000, 0, 0, 0, 0, 0));
  endtask

  task automatic tick();
    step(mk(0, 1, 4'b0000, 0, 0, 0, 0, 0));
  endtask

  vec_t tbl[12];
  int   pulses;
  vin_t rv;

  initial begin
    tbl[0]  = '{mk(1, 0, 4'b0000, 0, 0, 0, 0, 0), 2'b00, 3'd0, 1'b0, 8'd0};
    tbl[1]  = '{mk(0, 0, 4'b0000, 0, 0, 0, 0, 0), 2'b00, 3'd0, 1'b0, 8'd0};
    tbl[2]  = '{mk(0, 0, 4'b0001, 0, 0, 0, 0, 0), 2'b01, 3'd4, 1'b0, 8'd0};
    tbl[3]  = '{mk(0, 0, 4'b0000, 0, 0, 0, 0, 0), 2'b01, 3'd4, 1'b0, 8'd0};
    tbl[4]  = '{mk(0, 0, 4'b1000, 0, 0, 0, 0, 0), 2'b01, 3'd1, 1'b0, 8'd0};
    tbl[5]  = '{mk(0, 0, 4'b0010, 0, 0, 0, 0, 0), 2'b01, 3'd1, 1'b0, 8'd0};
    tbl[6]  = '{mk(0, 0, 4'b1100, 0, 0, 0, 0, 0), 2'b01, 3'd1, 1'b0, 8'd0};
    tbl[7]  = '{mk(1, 0, 4'b0000, 0, 0, 0, 0, 0), 2'b00, 3'd0, 1'b0, 8'd0};
    tbl[8]  = '{mk(1, 0, 4'b0100, 0, 0, 0, 0, 0), 2'b00, 3'd0, 1'b0, 8'd0};
    tbl[9]  = '{mk(0, 0, 4'b0100, 0, 0, 0, 0, 0), 2'b01, 3'd2, 1'b0, 8'd0};
    tbl[10] = '{mk(0, 0, 4'b0011, 0, 0, 0, 0, 0), 2'b01, 3'd3, 1'b0, 8'd0};
    tbl[11] = '{mk(1, 0, 4'b0000, 0, 0, 0, 0, 0), 2'b00, 3'd0, 1'b0, 8'd0};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].in);
      chk($sformatf("vec%0d_state", i), int'(game_state), int'(tbl[i].st));
      chk($sformatf("vec%0d_dir", i), int'(direction), int'(tbl[i].dir));
      chk($sformatf("vec%0d_update", i), int'(update), int'(tbl[i].upd));
      chk($sformatf("vec%0d_score", i), int'(score), int'(tbl[i].sc));
    end

    // Start moving right, then 16 frames: pulses right after the 8th and 16th tick.
    step(mk(0, 0, 4'b0001, 0, 0, 0, 0, 0));
    chk("start_state", int'(game_state), 1);
    chk("start_dir", int'(direction), 4);
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      idle();
      if (update) pulses++;
      idle();
      if (update) pulses++;
      tick();
      if (update) pulses++;
      chk($sformatf("upd_after_tick%0d", k), int'(update), (k % FPS == 0) ? 1 : 0);
    end
    idle();
    if (update) pulses++;
    chk("pulse_count", pulses, 2);
    chk("score_after_16", int'(score), 2);

    // Reversal built from two presses between moves is blocked until the next move.
    step(mk(0, 0, 4'b1000, 0, 0, 0, 0, 0));
    chk("turn_up", int'(direction), 1);
    step(mk(0, 0, 4'b0010, 0, 0, 0, 0, 0));
    chk("left_blocked", int'(direction), 1);
    for (int k = 1; k <= FPS; k++) begin
      idle();
      tick();
    end
    chk("reversal_update", int'(update), 1);
    step(mk(0, 0, 4'b0010, 0, 0, 0, 0, 0));
    chk("left_accepted", int'(direction), 3);
    chk("score_3", int'(score), 3);

    // Head on body latches; the next tick ends the game.
    step(mk(0, 0, 4'b0000, 1, 100, 100, 1, 1));
    chk("body_hit_still_play", int'(game_state), 1);
    idle();
    tick();
    chk("body_over_state", int'(game_state), 3);
    chk("body_over_update", int'(update), 0);
    chk("body_over_dir", int'(direction), 0);

    // GAME_OVER lasts GOF ticks, ignores buttons and keeps the score.
    for (int k = 1; k <= GOF; k++) begin
      step(mk(0, 0, 4'b1000, 0, 0, 0, 0, 0));
      chk("over_btn_dir", int'(direction), 0);
      tick();
      if (k == GOF - 1) chk("over_before_last", int'(game_state), 3);
    end
    chk("over_to_start", int'(game_state), 0);
    chk("start_score_held", int'(score), 3);
    idle();
    chk("start_idle_score", int'(score), 3);
    step(mk(0, 0, 4'b1000, 0, 0, 0, 0, 0));
    chk("restart_state", int'(game_state), 1);
    chk("restart_dir", int'(direction), 1);
    chk("restart_score", int'(score), 0);

    // Border checks around x/y limits.
    step(mk(0, 0, 4'b0000, 0, 3, 100, 1, 0));
    tick();
    chk("border_inactive_video", int'(game_state), 1);
    step(mk(0, 0, 4'b0000, 1, 5, 100, 1, 0));
    tick();
    chk("border_x5_safe", int'(game_state), 1);
    step(mk(0, 1, 4'b0000, 1, HA - BRD - 1, VA - BRD - 1, 1, 0));
    chk("border_inner_corner_safe", int'(game_state), 1);
    step(mk(0, 0, 4'b0000, 1, 3, 100, 1, 0));
    tick();
    chk("border_x3_over", int'(game_state), 3);
    step(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0));
    step(mk(0, 0, 4'b1000, 0, 0, 0, 0, 0));
    step(mk(0, 1, 4'b0000, 1, HA - BRD, 100, 1, 0));
    chk("border_same_cycle_over", int'(game_state), 3);
    chk("border_same_cycle_upd", int'(update), 0);
    step(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0));
    step(mk(0, 0, 4'b0001, 0, 0, 0, 0, 0));
    step(mk(0, 1, 4'b0000, 1, 200, VA - BRD, 1, 0));
    chk("border_y_bottom_over", int'(game_state), 3);

    // Reset during play with score 5.
    step(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0));
    step(mk(0, 0, 4'b0001, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5 * FPS; k++) tick();
    chk("score_5", int'(score), 5);
    step(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0));
    chk("rst_state", int'(game_state), 0);
    chk("rst_dir", int'(direction), 0);
    chk("rst_update", int'(update), 0);
    chk("rst_score", int'(score), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      rv.rst  = ($urandom_range(299, 0) == 0);
      rv.tick = ($urandom_range(3, 0) == 0);
      rv.btn  = {($urandom_range(9, 0) == 0), ($urandom_range(9, 0) == 0),
                 ($urandom_range(9, 0) == 0), ($urandom_range(9, 0) == 0)};
      rv.va   = ($urandom_range(3, 0) != 0);
      rv.x    = BIT'($urandom_range(HA - 1, 0));
      rv.y    = BIT'($urandom_range(VA - 1, 0));
      rv.head = ($urandom_range(59, 0) == 0);
      rv.body = ($urandom_range(2, 0) == 0);
      step(rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
